// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite slave with CTRL/DATA/STATUS/ID registers; define AXIL_REG_WSTRB_EN to honour byte strobes
module axil_reg_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RESP_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA11C_0001
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] OKAY   = '0;
    localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(2);

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e                w_state_q, w_state_d;
    r_state_e                r_state_q, r_state_d;
    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:2]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]           wstrb_q, wstrb_d;
    logic                    awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0]   bresp_q, bresp_d, rresp_q, rresp_d;
    logic                    arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   ctrl_q, ctrl_d, data_q, data_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   wmask, status, rd_word;
    logic                    aw_hit, ar_hit, unused_ok;

`ifdef AXIL_REG_WSTRB_EN
    // Expand latched byte strobes into a bit mask
    always_comb begin
        wmask = '0;
        for (int i = 0; i < SW; i++) wmask[8*i +: 8] = {8{wstrb_q[i]}};
    end
    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
    assign wmask     = '1;
    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], wstrb_q};
`endif

    assign aw_hit  = awaddr_q[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
    assign ar_hit  = s_axi_araddr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
    assign status  = {{(DATA_WIDTH-16){1'b0}}, cnt_q};
    assign rd_word = (s_axi_araddr[3:2] == 2'd0) ? ctrl_q :
                     (s_axi_araddr[3:2] == 2'd1) ? data_q :
                     (s_axi_araddr[3:2] == 2'd2) ? status : ID_VALUE;

    // Write FSM: latch AW and W independently, commit once both are held, then respond
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        if (w_state_q == W_IDLE) begin
            if (s_axi_awvalid && awready_q) begin
                aw_held_d = 1'b1;
                awaddr_d  = s_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (s_axi_wvalid && wready_q) begin
                w_held_d = 1'b1;
                wdata_d  = s_axi_wdata;
                wstrb_d  = s_axi_wstrb;
            end
            if (aw_held_q && w_held_q) begin
                w_state_d = W_RESP;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                bvalid_d  = 1'b1;
                bresp_d   = aw_hit ? OKAY : SLVERR;
                if (aw_hit) begin
                    cnt_d = cnt_q + 16'd1;
                    if (awaddr_q[3:2] == 2'd0) ctrl_d = (ctrl_q & ~wmask) | (wdata_q & wmask);
                    if (awaddr_q[3:2] == 2'd1) data_d = (data_q & ~wmask) | (wdata_q & wmask);
                end
            end
        end else if (s_axi_bready) begin
            w_state_d = W_IDLE;
            bvalid_d  = 1'b0;
        end
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // Write-path and register state
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            ctrl_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
        end
    end

    // Read FSM: sample the register file on the AR handshake and hold until rready
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (r_state_q == R_IDLE) begin
            if (s_axi_arvalid && arready_q) begin
                r_state_d = R_DATA;
                rvalid_d  = 1'b1;
                rdata_d   = ar_hit ? rd_word : '0;
                rresp_d   = ar_hit ? OKAY : SLVERR;
            end
        end else if (s_axi_rready) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
        end
        arready_d = r_state_d == R_IDLE;
    end

    // Read-path state
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: directed and randomized checks of axil_reg_slave against a register-map model
module tb_axil_reg_slave;
`ifdef AXIL_REG_WSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  bresp, rresp;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int aw_cyc, w_cyc;

    logic [31:0] ctrl_m, data_m;
    logic [15:0] cnt_m;

    axil_reg_slave dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i] || !STRB_EN) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [2:0] model_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a[7:4] != 4'h0) return 3'd2;
        cnt_m = cnt_m + 16'd1;
        if (a[3:2] == 2'd0) ctrl_m = mrg(ctrl_m, d, s);
        if (a[3:2] == 2'd1) data_m = mrg(data_m, d, s);
        return 3'd0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [7:0] a);
        if (a[7:4] != 4'h0) return 32'h0;
        case (a[3:2])
            2'd0:    return ctrl_m;
            2'd1:    return data_m;
            2'd2:    return {16'h0, cnt_m};
            default: return 32'hA11C_0001;
        endcase
    endfunction

    task automatic do_aw(input logic [7:0] a, input int dly);
        int n = 0;
        repeat (dly) @(negedge clk);
        awaddr = a;
        awvalid = 1'b1;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        chk("awready", awready, 1);
        aw_cyc = cyc;
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        int n = 0;
        repeat (dly) @(negedge clk);
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        while (!wready && n < 20) begin @(negedge clk); n++; end
        chk("wready", wready, 1);
        w_cyc = cyc;
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int awd, input int wd, input int stall);
        logic [2:0] er;
        int n = 0;
        int hs;
        er = model_wr(a, d, s);
        fork
            do_aw(a, awd);
            do_w(d, s, wd);
        join
        hs = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk("bvalid", bvalid, 1);
        chk("b_latency", cyc - hs, 2);
        chk("bresp", bresp, er);
        repeat (stall) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_hold", bresp, er);
            chk("awready_stall", awready, 0);
            chk("wready_stall", wready, 0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] ed, input logic [2:0] er,
                      input int ard, input int stall);
        int n = 0;
        int ac;
        repeat (ard) @(negedge clk);
        araddr = a;
        arvalid = 1'b1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        chk("arready", arready, 1);
        ac = cyc;
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        chk("rvalid", rvalid, 1);
        chk("r_latency", cyc - ac, 1);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        repeat (stall) begin
            @(negedge clk);
            chk("rvalid_hold", rvalid, 1);
            chk("rdata_hold", rdata, ed);
            chk("rresp_hold", rresp, er);
            chk("arready_stall", arready, 0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic rdm(input logic [7:0] a, input int stall);
        rd(a, model_rd(a), (a[7:4] != 4'h0) ? 3'd2 : 3'd0, 0, stall);
    endtask

    initial begin
        logic [31:0] exp_old, r;
        logic [7:0]  a;
        int n;
        rst_n = 1'b1;
        {awaddr, araddr, wdata, wstrb} = '0;
        {awvalid, wvalid, bready, arvalid, rready} = '0;
        ctrl_m = '0;
        data_m = '0;
        cnt_m = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 1);
        chk("post_rst_arready", arready, 1);

        wr(8'h00, 32'h1234_5678, 4'hF, 0, 0, 0);
        rd(8'h00, 32'h1234_5678, 3'd0, 0, 0);
        rd(8'h08, 32'h0000_0001, 3'd0, 0, 0);
        rd(8'h0C, 32'hA11C_0001, 3'd0, 0, 0);

        wr(8'h04, 32'hDEAD_BEEF, 4'hF, 3, 0, 0);
        rd(8'h04, 32'hDEAD_BEEF, 3'd0, 0, 0);
        wr(8'h00, 32'hCAFE_0001, 4'hF, 0, 2, 0);
        rdm(8'h00, 0);

        wr(8'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        wr(8'h04, 32'h0000_0000, 4'b0101, 0, 0, 0);
        rd(8'h04, STRB_EN ? 32'hFF00_FF00 : 32'h0000_0000, 3'd0, 0, 0);

        wr(8'h40, 32'h5555_AAAA, 4'hF, 0, 0, 0);
        rd(8'h40, 32'h0, 3'd2, 0, 0);
        rdm(8'h00, 0);
        rdm(8'h04, 0);
        rdm(8'h08, 0);

        wr(8'h08, 32'h1111_1111, 4'hF, 0, 0, 0);
        wr(8'h0D, 32'h2222_2222, 4'hF, 1, 0, 0);
        rdm(8'h0A, 0);
        rdm(8'h0F, 0);

        exp_old = model_rd(8'h00);
        fork
            wr(8'h04, 32'h0BAD_F00D, 4'hF, 0, 0, 5);
            rd(8'h00, exp_old, 3'd0, 0, 5);
        join

        exp_old = model_rd(8'h04);
        fork
            wr(8'h04, 32'h7777_0000, 4'hF, 0, 0, 0);
            rd(8'h04, exp_old, 3'd0, 1, 0);
        join
        rdm(8'h04, 0);

        for (int i = 0; i < 120; i++) begin
            a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom;
                wr(a, r, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
            end else begin
                rd(a, model_rd(a), (a[7:4] != 4'h0) ? 3'd2 : 3'd0, $urandom_range(0, 2), $urandom_range(0, 1));
            end
        end

        force dut.cnt_q = 16'hFFF0;
        @(negedge clk);
        release dut.cnt_q;
        cnt_m = 16'hFFF0;
        for (int i = 0; i < 15; i++) wr(8'h00, 32'($urandom), 4'hF, 0, 0, 0);
        rd(8'h08, 32'h0000_FFFF, 3'd0, 0, 0);
        wr(8'h0C, 32'h0, 4'hF, 0, 0, 0);
        rd(8'h08, 32'h0000_0000, 3'd0, 0, 0);

        wr(8'h00, 32'h0F0F_0F0F, 4'hF, 0, 0, 0);
        fork
            do_aw(8'h04, 0);
            do_w(32'hAAAA_5555, 4'hF, 0);
        join
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk("pre_rst_bvalid", bvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_arready", arready, 0);
        chk("mid_rst_rdata", rdata, 0);
        ctrl_m = '0;
        data_m = '0;
        cnt_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_b_after_rst", bvalid, 0);
            chk("no_r_after_rst", rvalid, 0);
        end
        rd(8'h00, 32'h0, 3'd0, 0, 0);
        rd(8'h04, 32'h0, 3'd0, 0, 0);
        rd(8'h08, 32'h0, 3'd0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
